// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and the core it feeds.
// Holds the loader state encoding, error codes and the processor opcode constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CSUM,
        FILL,
        RUN,
        ERR
    } state_t;

    // Processor opcodes live in the top two bits of each instruction byte.
    localparam logic [1:0] OP_NOP    = 2'b10;
    localparam logic [7:0] NOP_INSTR = {OP_NOP, 6'd0};

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // A frame is good when LEN, every data byte and CSUM add to zero mod 256.
    function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] csum);
        logic [7:0] total;
        total = sum + csum;
        return (total == 8'd0);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write port and status signals of the loader.
// The loader uses the master view; the host/memory/core side uses the slave view.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    import imem_loader_pkg::*;

    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              load_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_reset_n;
    logic              done;
    logic [1:0]        err;

    modport master (
        input  s_valid, s_data, load_req,
        output s_ready, mem_we, mem_addr, mem_wdata, cpu_reset_n, done, err
    );

    modport slave (
        output s_valid, s_data, load_req,
        input  s_ready, mem_we, mem_addr, mem_wdata, cpu_reset_n, done, err
    );

endinterface

// File: rtl/imem_loader.sv
// Receives a LEN/data/CSUM framed program, writes it into instruction memory, pads the
// rest with NOPs and releases the core from reset only once the whole image is resident.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.master bus
);

    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C     = (ADDR_W+1)'(1);
    localparam logic [7:0]      DEPTH_B   = 8'(DEPTH);
    localparam logic [7:0]      TIMEOUT_C = 8'(TIMEOUT);

    state_t          state;
    logic [ADDR_W:0] cnt;
    logic [ADDR_W:0] len;
    logic [7:0]      sum;
    logic [7:0]      idle;
    logic            xfer;

    assign bus.s_ready = (state == HDR) || (state == DATA) || (state == CSUM);
    assign xfer        = bus.s_valid && bus.s_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= HDR;
            cnt             <= '0;
            len             <= '0;
            sum             <= '0;
            idle            <= '0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.cpu_reset_n <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= ERR_NONE;
        end else begin
            bus.mem_we <= 1'b0;
            // A reload request wins over everything, including a byte offered this cycle.
            if (bus.load_req) begin
                state           <= HDR;
                cnt             <= '0;
                sum             <= '0;
                idle            <= '0;
                bus.cpu_reset_n <= 1'b0;
                bus.done        <= 1'b0;
                bus.err         <= ERR_NONE;
            end else begin
                case (state)
                    HDR: begin
                        if (xfer) begin
                            if (bus.s_data == 8'd0 || bus.s_data > DEPTH_B) begin
                                state   <= ERR;
                                bus.err <= ERR_LEN;
                            end else begin
                                len   <= bus.s_data[ADDR_W:0];
                                sum   <= bus.s_data;
                                cnt   <= '0;
                                idle  <= '0;
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (xfer) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= cnt[ADDR_W-1:0];
                            bus.mem_wdata <= bus.s_data;
                            sum           <= sum + bus.s_data;
                            cnt           <= cnt + ONE_C;
                            idle          <= '0;
                            if (cnt == len - ONE_C)
                                state <= CSUM;
                        end else if (idle == TIMEOUT_C - 8'd1) begin
                            state   <= ERR;
                            bus.err <= ERR_TIMEOUT;
                        end else begin
                            idle <= idle + 8'd1;
                        end
                    end
                    CSUM: begin
                        if (xfer) begin
                            idle <= '0;
                            if (csum_ok(sum, bus.s_data)) begin
                                cnt   <= len;
                                // A full-depth image has nothing left to pad.
                                state <= (len == DEPTH_C) ? RUN : FILL;
                            end else begin
                                state   <= ERR;
                                bus.err <= ERR_CSUM;
                            end
                        end else if (idle == TIMEOUT_C - 8'd1) begin
                            state   <= ERR;
                            bus.err <= ERR_TIMEOUT;
                        end else begin
                            idle <= idle + 8'd1;
                        end
                    end
                    FILL: begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= cnt[ADDR_W-1:0];
                        bus.mem_wdata <= NOP_INSTR;
                        cnt           <= cnt + ONE_C;
                        if (cnt == DEPTH_C - ONE_C)
                            state <= RUN;
                    end
                    RUN: begin
                        bus.cpu_reset_n <= 1'b1;
                        bus.done        <= 1'b1;
                    end
                    ERR: begin
                        bus.cpu_reset_n <= 1'b0;
                        bus.done        <= 1'b0;
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end

endmodule
